// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
//
// Shared definitions for the run-time power-of-two clock divider controller.
//
// Contents:
//   DEF_NUM_RATIOS  default number of selectable ratios (sel k divides by 2^(k+1))
//   DEF_SEL_W       default width of the ratio select fields
//   state_t         controller FSM states (IDLE, WAIT_ALIGN, DONE)
//   SEL_DIV2..32    named select codes for the default ratio set
// -----------------------------------------------------------------------------
package clk_div_pkg;

   localparam int DEF_NUM_RATIOS = 5;
   localparam int DEF_SEL_W      = 3;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_ALIGN = 2'd1,
      DONE       = 2'd2
   } state_t;

   localparam logic [DEF_SEL_W-1:0] SEL_DIV2  = 3'd0;
   localparam logic [DEF_SEL_W-1:0] SEL_DIV4  = 3'd1;
   localparam logic [DEF_SEL_W-1:0] SEL_DIV8  = 3'd2;
   localparam logic [DEF_SEL_W-1:0] SEL_DIV16 = 3'd3;
   localparam logic [DEF_SEL_W-1:0] SEL_DIV32 = 3'd4;

endpackage

// File: rtl/clk_div_align.sv
// -----------------------------------------------------------------------------
// clk_div_align
//
// Divide counter plus the comparators that derive the divided outputs and the
// ratio-change alignment condition.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   run       in   1 = counter advances, 0 = counter cleared every cycle
//   cur_sel   in   ratio currently applied
//   pend_sel  in   ratio waiting to be applied (must be in range)
//   aligned   out  low bits of cnt up to max(cur_sel, pend_sel) are all ones
//   tick      out  last clk of the current div_out period
//   div_out   out  divided square wave, 50% duty
// -----------------------------------------------------------------------------
module clk_div_align
   import clk_div_pkg::*;
#(
   parameter int NUM_RATIOS = DEF_NUM_RATIOS,
   parameter int SEL_W      = DEF_SEL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [SEL_W-1:0] cur_sel,
   input  logic [SEL_W-1:0] pend_sel,
   output logic             aligned,
   output logic             tick,
   output logic             div_out
);

   localparam logic [NUM_RATIOS-1:0] CNT_ONE = NUM_RATIOS'(1);

   // Bits [sel:0] set. Built by comparison so an out-of-range select can
   // never index past the counter; it simply saturates to all ones.
   function automatic logic [NUM_RATIOS-1:0] low_mask(input logic [SEL_W-1:0] sel);
      logic [NUM_RATIOS-1:0] m;
      for (int i = 0; i < NUM_RATIOS; i++) begin
         m[i] = (i <= int'(sel));
      end
      return m;
   endfunction

   // Only bit [sel] set.
   function automatic logic [NUM_RATIOS-1:0] bit_mask(input logic [SEL_W-1:0] sel);
      logic [NUM_RATIOS-1:0] m;
      for (int i = 0; i < NUM_RATIOS; i++) begin
         m[i] = (i == int'(sel));
      end
      return m;
   endfunction

   logic [NUM_RATIOS-1:0] cnt;
   logic [NUM_RATIOS-1:0] cur_mask;
   logic [NUM_RATIOS-1:0] both_mask;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!run) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   // The union of the two low masks is the mask of the larger select, so
   // this is cnt[max(cur,pend):0] == all ones without computing the max.
   always_comb begin
      cur_mask  = low_mask(cur_sel);
      both_mask = cur_mask | low_mask(pend_sel);
      aligned   = ((cnt & both_mask) == both_mask);
      tick      = run & ((cnt & cur_mask) == cur_mask);
      div_out   = run & (|(cnt & bit_mask(cur_sel)));
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Run-time controller for the power-of-two clock divider. A ratio change is
// requested through a valid/ready handshake and applied only when the counter
// sits at a common period boundary of the old and new ratios, so div_out and
// tick never show a runt or shortened phase.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   run        in   1 = divider runs, 0 = counter held at 0 and outputs low
//   req_valid  in   ratio-change request
//   req_sel    in   requested ratio select (divide by 2^(req_sel+1))
//   req_ready  out  block can accept a request (IDLE)
//   chg_done   out  one-cycle pulse when the new ratio is in effect
//   req_err    out  one-cycle pulse when an out-of-range request is rejected
//   cur_sel    out  ratio select currently applied
//   div_out    out  divided square wave, 50% duty
//   tick       out  one-cycle pulse on the last clk of each div_out period
// -----------------------------------------------------------------------------
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int NUM_RATIOS = DEF_NUM_RATIOS,
   parameter int SEL_W      = DEF_SEL_W,
   parameter int RESET_SEL  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             req_valid,
   input  logic [SEL_W-1:0] req_sel,
   output logic             req_ready,
   output logic             chg_done,
   output logic             req_err,
   output logic [SEL_W-1:0] cur_sel,
   output logic             div_out,
   output logic             tick
);

   localparam logic [SEL_W-1:0] RST_SEL   = SEL_W'(RESET_SEL);
   localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W+1)'(NUM_RATIOS);

   state_t           state_q;
   state_t           state_d;
   logic [SEL_W-1:0] pend_q;
   logic [SEL_W-1:0] pend_d;
   logic [SEL_W-1:0] cur_q;
   logic [SEL_W-1:0] cur_d;
   logic             err_q;
   logic             err_d;
   logic             aligned;
   logic             sel_bad;

   clk_div_align #(
      .NUM_RATIOS (NUM_RATIOS),
      .SEL_W      (SEL_W)
   ) u_align (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .cur_sel  (cur_q),
      .pend_sel (pend_q),
      .aligned  (aligned),
      .tick     (tick),
      .div_out  (div_out)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pend_q  <= RST_SEL;
         cur_q   <= RST_SEL;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cur_q   <= cur_d;
         err_q   <= err_d;
      end
   end

   assign sel_bad = ({1'b0, req_sel} >= SEL_LIMIT);

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      cur_d   = cur_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (sel_bad) begin
                  err_d = 1'b1;
               end else begin
                  pend_d  = req_sel;
                  state_d = WAIT_ALIGN;
               end
            end
         end
         WAIT_ALIGN: begin
            // With run low the counter is already 0 and outputs are low, so
            // there is no phase to protect; an unchanged ratio needs no wait.
            if (aligned || !run || (pend_q == cur_q)) begin
               cur_d   = pend_q;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign req_ready = (state_q == IDLE);
   assign chg_done  = (state_q == DONE);
   assign req_err   = err_q;
   assign cur_sel   = cur_q;

endmodule
